dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single data memory port between the RV32I core's load/store path and an external DMA/loader master. It sits between the core (address from Result, store data from Rs2, MemOp, MemWr) and the data memory, whose read data is registered one cycle after the address. It issues at most one access per cycle, alternates fairly under contention, and routes read data back to the requester that issued the read.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- CoreReq  input  1  core requests an access; held with payload until CoreGnt.
- CoreWe  input  1  1 = store, 0 = load.
- CoreAddr  input  32  byte address.
- CoreWdata  input  32  store data.
- CoreMemOp  input  3  access size/sign, passed through unchanged.
- CoreGnt  output  1  access issued to memory this cycle.
- CoreStall  output  1  CoreReq & ~CoreGnt; freezes the core PC and register write.
- CoreRvalid  output  1  CoreRdata valid this cycle.
- CoreRdata  output  32  load data.
- DmaReq, DmaWe, DmaAddr[31:0], DmaWdata[31:0], DmaMemOp[2:0]  input  same meaning for the DMA master.
- DmaGnt, DmaRvalid, DmaRdata[31:0]  output  same meaning for the DMA master.
- MemAddr  output  32  to DataMem Addr.
- MemOp  output  3  to DataMem MemOp.
- MemDataIn  output  32  to DataMem DataIn.
- MemWrEn  output  1  to DataMem WrEn.
- MemRdData  input  32  DataMem DataOut; valid in the cycle after the read address.

## Operation
- State machine:
  - IDLE: accepts requests.
  - RD: read in flight; no grants are issued.
- Registers:
  - State; reset IDLE.
  - LastGnt: 0 = core, 1 = DMA; reset 1, so the core wins the first contention.
  - RdOwner; reset 0.
- Grant in IDLE (combinational):
  - Exactly one requester active: that requester is granted.
  - Both active: the requester that is not LastGnt is granted.
  - LastGnt updates only on contended grants.
- Memory mux:
  - Granted requester's Addr, Wdata and MemOp drive MemAddr, MemDataIn and MemOp.
  - MemWrEn = grant & We.
  - With no grant: MemWrEn = 0 and the Mem* outputs hold the core's payload.
- Grant of a write: State stays IDLE, so the next cycle can grant again.
- Grant of a read: State goes to RD and RdOwner captures the owner.
- RD: the owner's Rvalid = 1 and its Rdata = MemRdData; the other Rvalid = 0. RD returns to IDLE unconditionally.
- Rdata outputs of a non-owner hold their last delivered value (reset 0).
- Requesters must hold Req and payload stable until Gnt. Dropping Req before Gnt is legal and means no access.
- A grant is never issued in RD, even for a write.

## Timing
- Gnt, CoreStall, MemWrEn and Mem* are combinational from Req, State and LastGnt in the same cycle.
- Write: granted in cycle N; memory writes at the rising edge ending cycle N.
- Read: granted in cycle N; Rvalid and Rdata are valid in cycle N+1; earliest next grant is cycle N+2.
- Throughput: 1 write per cycle, 1 read per 2 cycles.
- Reset asserted (Rst = 0), including mid-read:
  - State = IDLE, LastGnt = 1, RdOwner = 0.
  - Both Rvalid = 0; the in-flight read is discarded.
  - All Gnt = 0, MemWrEn = 0, CoreStall = 0.
  - Rdata = 0.
- First cycle after reset release: arbitration is normal.
- Simultaneous Req in RD: both wait; in the next IDLE cycle the not-LastGnt requester wins.

## Test plan
- Core-only store then load, addr 0x10, data 0xDEADBEEF:
  - Store: CoreGnt=1, MemWrEn=1 in the same cycle.
  - Load: CoreGnt cycle N, then CoreRvalid=1 with CoreRdata=0xDEADBEEF in N+1; DmaRvalid=0.
- Both request writes continuously from reset:
  - Grants alternate core, DMA, core, DMA on consecutive cycles.
  - No stall gaps; CoreStall=1 exactly on DMA cycles.
- Both request reads:
  - Core granted cycle N, CoreRvalid in N+1, no grant in N+1.
  - DMA granted N+2, DmaRvalid in N+3.
- DMA read at 0x20 holding 0x12345678 while core idle:
  - DmaRvalid=1, DmaRdata=0x12345678 one cycle after DmaGnt.
  - CoreRvalid stays 0 and CoreRdata is unchanged.
- Rst asserted in the RD cycle of a core read:
  - CoreRvalid=0 immediately; after release State=IDLE.
  - With both Req, the core is granted first.
- Req dropped before grant (DMA Req for 1 cycle during a core RD):
  - No DmaGnt and no memory access issued for the DMA.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter
// and the single-ported data memory.
interface dmem_arbiter_if;
    logic        CoreReq;
    logic        CoreWe;
    logic [31:0] CoreAddr;
    logic [31:0] CoreWdata;
    logic [2:0]  CoreMemOp;
    logic        CoreGnt;
    logic        CoreStall;
    logic        CoreRvalid;
    logic [31:0] CoreRdata;

    logic        DmaReq;
    logic        DmaWe;
    logic [31:0] DmaAddr;
    logic [31:0] DmaWdata;
    logic [2:0]  DmaMemOp;
    logic        DmaGnt;
    logic        DmaRvalid;
    logic [31:0] DmaRdata;

    logic [31:0] MemAddr;
    logic [2:0]  MemOp;
    logic [31:0] MemDataIn;
    logic        MemWrEn;
    logic [31:0] MemRdData;

    modport master (
        output CoreReq, CoreWe, CoreAddr, CoreWdata, CoreMemOp,
        input  CoreGnt, CoreStall, CoreRvalid, CoreRdata,
        output DmaReq, DmaWe, DmaAddr, DmaWdata, DmaMemOp,
        input  DmaGnt, DmaRvalid, DmaRdata,
        input  MemAddr, MemOp, MemDataIn, MemWrEn,
        output MemRdData
    );

    modport slave (
        input  CoreReq, CoreWe, CoreAddr, CoreWdata, CoreMemOp,
        output CoreGnt, CoreStall, CoreRvalid, CoreRdata,
        input  DmaReq, DmaWe, DmaAddr, DmaWdata, DmaMemOp,
        output DmaGnt, DmaRvalid, DmaRdata,
        output MemAddr, MemOp, MemDataIn, MemWrEn,
        input  MemRdData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter for the single data memory port.
// Alternates under contention and steers read data back to its owner.
module dmem_arbiter (
    input logic           Clk,
    input logic           Rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RD   = 1'b1;

    logic [0:0]  state;
    logic        last_gnt;
    logic        rd_owner;
    logic [31:0] core_rdata_q;
    logic [31:0] dma_rdata_q;

    logic        in_rd;
    logic        contend;
    logic        core_gnt;
    logic        dma_gnt;
    logic        any_gnt;
    logic        gnt_we;

    // Grant decision: nothing in reset or while a read is in flight,
    // otherwise the lone requester or the one that did not win last.
    always_comb begin
        in_rd    = (state == RD);
        contend  = bus.CoreReq & bus.DmaReq;
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (Rst && !in_rd) begin
            if (contend) begin
                core_gnt = last_gnt;
                dma_gnt  = ~last_gnt;
            end else begin
                core_gnt = bus.CoreReq;
                dma_gnt  = bus.DmaReq;
            end
        end
        any_gnt = core_gnt | dma_gnt;
        gnt_we  = (core_gnt & bus.CoreWe) | (dma_gnt & bus.DmaWe);
    end

    assign bus.CoreGnt   = core_gnt;
    assign bus.DmaGnt    = dma_gnt;
    assign bus.CoreStall = Rst & bus.CoreReq & ~core_gnt;

    // Memory side: core payload is parked on the bus when DMA is not granted.
    assign bus.MemAddr   = dma_gnt ? bus.DmaAddr  : bus.CoreAddr;
    assign bus.MemDataIn = dma_gnt ? bus.DmaWdata : bus.CoreWdata;
    assign bus.MemOp     = dma_gnt ? bus.DmaMemOp : bus.CoreMemOp;
    assign bus.MemWrEn   = gnt_we;

    // Read return: owner sees live memory data, other side holds its last value.
    assign bus.CoreRvalid = in_rd & ~rd_owner;
    assign bus.DmaRvalid  = in_rd & rd_owner;
    assign bus.CoreRdata  = bus.CoreRvalid ? bus.MemRdData : core_rdata_q;
    assign bus.DmaRdata   = bus.DmaRvalid  ? bus.MemRdData : dma_rdata_q;

    // Control state: read occupancy, fairness pointer and read owner.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            rd_owner <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_gnt) begin
                        if (contend) begin
                            last_gnt <= dma_gnt;
                        end
                        if (!gnt_we) begin
                            state    <= RD;
                            rd_owner <= dma_gnt;
                        end
                    end
                end
                RD: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Hold the last delivered read data per requester.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else if (in_rd) begin
            if (rd_owner) begin
                dma_rdata_q <= bus.MemRdData;
            end else begin
                core_rdata_q <= bus.MemRdData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

    logic Clk;
    logic Rst;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory: synchronous write, read data registered one cycle later.
    logic [31:0] mem [0:63];
    always @(posedge Clk) begin
        if (bus.MemWrEn) mem[bus.MemAddr[7:2]] <= bus.MemDataIn;
        bus.MemRdData <= mem[bus.MemAddr[7:2]];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level).
    logic [31:0] ref_mem [0:63];
    bit          m_in_rd;
    bit          m_owner;
    bit          m_last;
    logic [31:0] m_rd_val;
    logic [31:0] m_held [0:1];
    bit          m_cg;
    bit          m_dg;

    // Random requester state.
    bit          creq, cwe, dreq, dwe;
    logic [31:0] caddr, cdat, daddr, ddat;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst,
                         input bit cr, input bit cw,
                         input logic [31:0] ca, input logic [31:0] cd,
                         input bit dr, input bit dw,
                         input logic [31:0] da, input logic [31:0] dd);
        int          win;
        logic [2:0]  cop;
        logic [2:0]  dop;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          we;
        @(negedge Clk);
        cop = 3'($urandom_range(0, 7));
        dop = 3'($urandom_range(0, 7));
        bus.CoreReq   = cr;
        bus.CoreWe    = cw;
        bus.CoreAddr  = ca;
        bus.CoreWdata = cd;
        bus.CoreMemOp = cop;
        bus.DmaReq    = dr;
        bus.DmaWe     = dw;
        bus.DmaAddr   = da;
        bus.DmaWdata  = dd;
        bus.DmaMemOp  = dop;
        Rst           = rst;
        if (!rst) begin
            m_in_rd   = 1'b0;
            m_owner   = 1'b0;
            m_last    = 1'b1;
            m_held[0] = '0;
            m_held[1] = '0;
        end
        win = -1;
        if (rst && !m_in_rd) begin
            if (cr && dr) win = m_last ? 0 : 1;
            else if (cr)  win = 0;
            else if (dr)  win = 1;
        end
        #1;
        chk("core_gnt", 32'(bus.CoreGnt), 32'(win == 0));
        chk("dma_gnt", 32'(bus.DmaGnt), 32'(win == 1));
        chk("core_stall", 32'(bus.CoreStall), 32'(rst && cr && win != 0));
        chk("mem_wren", 32'(bus.MemWrEn),
            32'((win == 0 && cw) || (win == 1 && dw)));
        chk("mem_addr", bus.MemAddr, (win == 1) ? da : ca);
        chk("mem_din", bus.MemDataIn, (win == 1) ? dd : cd);
        chk("mem_op", 32'(bus.MemOp), 32'((win == 1) ? dop : cop));
        chk("core_rvalid", 32'(bus.CoreRvalid), 32'(m_in_rd && !m_owner));
        chk("dma_rvalid", 32'(bus.DmaRvalid), 32'(m_in_rd && m_owner));
        chk("core_rdata", bus.CoreRdata,
            (m_in_rd && !m_owner) ? m_rd_val : m_held[0]);
        chk("dma_rdata", bus.DmaRdata,
            (m_in_rd && m_owner) ? m_rd_val : m_held[1]);
        m_cg = (win == 0);
        m_dg = (win == 1);
        if (rst) begin
            if (m_in_rd) begin
                m_held[m_owner] = m_rd_val;
                m_in_rd = 1'b0;
            end else if (win >= 0) begin
                wa = (win == 1) ? da : ca;
                wd = (win == 1) ? dd : cd;
                we = (win == 1) ? dw : cw;
                if (cr && dr) m_last = (win == 1);
                if (we) begin
                    ref_mem[wa[7:2]] = wd;
                end else begin
                    m_in_rd  = 1'b1;
                    m_owner  = (win == 1);
                    m_rd_val = ref_mem[wa[7:2]];
                end
            end
        end
    endtask

    initial begin
        Rst = 1'b0;
        m_cg = 1'b0;
        m_dg = 1'b0;
        // Reset with both requesting: no grants, no stall.
        drive(0, 1, 1, 32'h0, 32'h1, 1, 1, 32'h4, 32'h2);
        drive(0, 1, 0, 32'h8, 32'h3, 1, 0, 32'hC, 32'h4);
        // Fill memory with known contents.
        for (int i = 0; i < 64; i++)
            drive(1, 1, 1, 32'(i) << 2, $urandom, 0, 0, 0, 0);
        // Core store then load at 0x10.
        drive(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        // Continuous contended writes from reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            drive(1, 1, 1, 32'h40 + 32'(k * 4), $urandom,
                  1, 1, 32'h80 + 32'(k * 4), $urandom);
        // Contended reads.
        drive(1, 1, 0, 32'h10, 0, 1, 0, 32'h40, 0);
        drive(1, 0, 0, 32'h10, 0, 1, 0, 32'h40, 0);
        drive(1, 0, 0, 32'h10, 0, 1, 0, 32'h40, 0);
        drive(1, 0, 0, 32'h10, 0, 0, 0, 32'h40, 0);
        // DMA write then read at 0x20 while core idle.
        drive(1, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
        drive(1, 0, 0, 0, 0, 1, 0, 32'h20, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h20, 0);
        // Reset during the RD cycle of a core read.
        drive(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h14, 0, 1, 0, 32'h24, 0);
        drive(1, 1, 0, 32'h14, 0, 1, 0, 32'h24, 0);
        drive(1, 0, 0, 32'h14, 0, 1, 0, 32'h24, 0);
        drive(1, 0, 0, 32'h14, 0, 1, 0, 32'h24, 0);
        drive(1, 0, 0, 32'h14, 0, 0, 0, 32'h24, 0);
        // DMA request dropped during a core read.
        drive(1, 1, 0, 32'h18, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 32'h18, 0, 1, 1, 32'h28, 32'hCAFEF00D);
        drive(1, 0, 0, 32'h18, 0, 0, 0, 32'h28, 0);
        // Random traffic with occasional drops and resets.
        creq = 1'b0;
        dreq = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!creq || m_cg) begin
                creq  = ($urandom_range(0, 9) < 6);
                cwe   = 1'($urandom_range(0, 1));
                caddr = 32'($urandom_range(0, 63)) << 2;
                cdat  = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                creq = 1'b0;
            end
            if (!dreq || m_dg) begin
                dreq  = ($urandom_range(0, 9) < 6);
                dwe   = 1'($urandom_range(0, 1));
                daddr = 32'($urandom_range(0, 63)) << 2;
                ddat  = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                dreq = 1'b0;
            end
            drive(($urandom_range(0, 99) != 0), creq, cwe, caddr, cdat,
                  dreq, dwe, daddr, ddat);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
